// File: rtl/otter_csr_intr_if.sv
// Bus between the Otter CU and the machine-mode CSR/interrupt block.
// master: the CU side that drives retire/CSR strobes. slave: the CSR block.
interface otter_csr_intr_if;
  logic        intr;
  logic        instr_done;
  logic        csr_we;
  logic        mret_exec;
  logic [11:0] csr_addr;
  logic [31:0] csr_wd;
  logic [31:0] pc_next;
  logic        int_taken;
  logic [31:0] csr_rd;
  logic [31:0] mepc;
  logic [31:0] mtvec;
  logic        mie_out;

  modport master (
    output intr, instr_done, csr_we, mret_exec, csr_addr, csr_wd, pc_next,
    input  int_taken, csr_rd, mepc, mtvec, mie_out
  );

  modport slave (
    input  intr, instr_done, csr_we, mret_exec, csr_addr, csr_wd, pc_next,
    output int_taken, csr_rd, mepc, mtvec, mie_out
  );
endinterface

// File: rtl/otter_csr_intr.sv
// Machine-mode CSR file (mstatus/mtvec/mepc/mcause) and external interrupt
// responder for the Otter RV32I core. Interrupts are only taken at retire.
module otter_csr_intr #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] MCAUSE_VAL  = 32'h8000000B
) (
  input logic               CLK,
  input logic               RST,
  otter_csr_intr_if.slave   bus
);

  localparam logic [11:0] AddrMstatus = 12'h300;
  localparam logic [11:0] AddrMtvec   = 12'h305;
  localparam logic [11:0] AddrMepc    = 12'h341;
  localparam logic [11:0] AddrMcause  = 12'h342;

  typedef enum logic {StIdle, StTake} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   intr_s_prev_q;
  logic                   pending_q, pending_d;
  logic                   mie_q, mie_d, mpie_q, mpie_d;
  logic                   mie_nx, mpie_nx;
  logic [31:0]            mtvec_q, mtvec_d;
  logic [31:0]            mepc_q, mepc_d;
  logic [31:0]            rd_val;
  logic                   intr_s, intr_rise;
  logic                   wr_en, mret_en, take;

  assign intr_s    = sync_q[SYNC_STAGES-1];
  assign intr_rise = intr_s & ~intr_s_prev_q;
  assign wr_en     = bus.csr_we & bus.instr_done;
  assign mret_en   = bus.mret_exec & bus.instr_done;
  assign take      = (state_q == StTake);

  // Synchronizer chain and edge-detect history for the async intr level.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q        <= '0;
      intr_s_prev_q <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], bus.intr};
      intr_s_prev_q <= intr_s;
    end
  end

  // Combinational CSR read; shows pre-write state during a write cycle.
  always_comb begin
    rd_val = 32'h0;
    case (bus.csr_addr)
      AddrMstatus: rd_val = {24'h0, mpie_q, 3'b000, mie_q, 3'b000};
      AddrMtvec:   rd_val = mtvec_q;
      AddrMepc:    rd_val = mepc_q;
      AddrMcause:  rd_val = MCAUSE_VAL;
      default:     rd_val = 32'h0;
    endcase
  end

  // mstatus after this cycle's CSR write / MRET, ignoring interrupt entry.
  // MRET is applied last so it wins over a coincident mstatus write.
  always_comb begin
    mie_nx  = mie_q;
    mpie_nx = mpie_q;
    if (wr_en && bus.csr_addr == AddrMstatus) begin
      mie_nx  = bus.csr_wd[3];
      mpie_nx = bus.csr_wd[7];
    end
    if (mret_en) begin
      mie_nx  = mpie_q;
      mpie_nx = 1'b1;
    end
  end

  // Register next-state; TAKE updates override CSR writes, and a fresh
  // intr edge in the TAKE cycle re-arms pending.
  always_comb begin
    mie_d     = mie_nx;
    mpie_d    = mpie_nx;
    mtvec_d   = mtvec_q;
    mepc_d    = mepc_q;
    pending_d = pending_q;
    if (wr_en && bus.csr_addr == AddrMtvec) mtvec_d = bus.csr_wd & 32'hFFFF_FFFC;
    if (wr_en && bus.csr_addr == AddrMepc)  mepc_d  = bus.csr_wd & 32'hFFFF_FFFC;
    if (take) begin
      mie_d     = 1'b0;
      mpie_d    = mie_q;
      mepc_d    = bus.pc_next & 32'hFFFF_FFFC;
      pending_d = 1'b0;
    end
    if (intr_rise) pending_d = 1'b1;
  end

  // Entry FSM: TAKE is a single-cycle state entered only at retire.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.instr_done && pending_q && mie_nx) state_d = StTake;
      StTake: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // CSR, pending and FSM state registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      pending_q <= 1'b0;
      mie_q     <= 1'b0;
      mpie_q    <= 1'b0;
      mtvec_q   <= 32'h0;
      mepc_q    <= 32'h0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mie_q     <= mie_d;
      mpie_q    <= mpie_d;
      mtvec_q   <= mtvec_d;
      mepc_q    <= mepc_d;
    end
  end

  assign bus.int_taken = take;
  assign bus.csr_rd    = rd_val;
  assign bus.mepc      = mepc_q;
  assign bus.mtvec     = mtvec_q;
  assign bus.mie_out   = mie_q;

endmodule

// File: tb/tb_otter_csr_intr.sv
// Directed bench for otter_csr_intr: CSR vector table plus hand sequences
// for interrupt entry, masking, MRET, level-held intr and reset mid-TAKE.
module tb_otter_csr_intr;

  logic CLK = 1'b0;
  logic RST;
  otter_csr_intr_if bus();

  otter_csr_intr #(
    .SYNC_STAGES (2),
    .MCAUSE_VAL  (32'h8000000B)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [31:0] exp_mtvec;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic retire(input logic we, input logic mret, input logic [11:0] addr,
                        input logic [31:0] wd, input logic [31:0] pc);
    bus.instr_done = 1'b1;
    bus.csr_we     = we;
    bus.mret_exec  = mret;
    bus.csr_addr   = addr;
    bus.csr_wd     = wd;
    bus.pc_next    = pc;
    tick();
    bus.instr_done = 1'b0;
    bus.csr_we     = 1'b0;
    bus.mret_exec  = 1'b0;
  endtask

  task automatic check_rd(input string name, input logic [11:0] addr, input logic [31:0] exp);
    bus.csr_addr = addr;
    #1;
    check(name, bus.csr_rd, exp);
  endtask

  initial begin
    vecs[0] = '{1'b1, 12'h305, 32'h0000_0103, 32'h0000_0100, 32'h0000_0100};
    vecs[1] = '{1'b1, 12'h341, 32'h1234_5677, 32'h1234_5674, 32'h0000_0100};
    vecs[2] = '{1'b0, 12'h342, 32'h0000_0000, 32'h8000_000B, 32'h0000_0100};
    vecs[3] = '{1'b1, 12'h342, 32'hFFFF_FFFF, 32'h8000_000B, 32'h0000_0100};
    vecs[4] = '{1'b1, 12'h123, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0100};
    vecs[5] = '{1'b1, 12'h300, 32'hFFFF_FF77, 32'h0000_0000, 32'h0000_0100};
    vecs[6] = '{1'b0, 12'h305, 32'hFFFF_FFF0, 32'h0000_0100, 32'h0000_0100};
    vecs[7] = '{1'b1, 12'h341, 32'h0000_0000, 32'h0000_0000, 32'h0000_0100};

    bus.intr       = 1'b1;
    bus.instr_done = 1'b0;
    bus.csr_we     = 1'b0;
    bus.mret_exec  = 1'b0;
    bus.csr_addr   = 12'h0;
    bus.csr_wd     = 32'h0;
    bus.pc_next    = 32'h0;
    RST            = 1'b1;

    // Reset with intr held high
    idle(2);
    check("rst_int_taken", {31'h0, bus.int_taken}, 32'h0);
    check("rst_mepc", bus.mepc, 32'h0);
    check("rst_mtvec", bus.mtvec, 32'h0);
    check("rst_mie", {31'h0, bus.mie_out}, 32'h0);
    check_rd("rst_mstatus", 12'h300, 32'h0);
    RST = 1'b0;
    idle(4);
    retire(1'b0, 1'b0, 12'h0, 32'h0, 32'h10);
    check("masked_no_take", {31'h0, bus.int_taken}, 32'h0);

    // CSR table; pending is set but MIE stays 0, so no entry may occur
    for (int i = 0; i < 8; i++) begin
      retire(vecs[i].we, 1'b0, vecs[i].addr, vecs[i].wd, 32'h20);
      check_rd($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].exp_rd);
      check($sformatf("vec%0d_mtvec", i), bus.mtvec, vecs[i].exp_mtvec);
      check($sformatf("vec%0d_no_take", i), {31'h0, bus.int_taken}, 32'h0);
    end

    // csr_we without instr_done is ignored
    bus.csr_we   = 1'b1;
    bus.csr_addr = 12'h305;
    bus.csr_wd   = 32'h200;
    tick();
    bus.csr_we = 1'b0;
    check("we_unqualified", bus.mtvec, 32'h100);

    // Read during write cycle returns the pre-write value
    bus.instr_done = 1'b1;
    bus.csr_we     = 1'b1;
    bus.csr_addr   = 12'h305;
    bus.csr_wd     = 32'h404;
    #1;
    check("rd_prewrite", bus.csr_rd, 32'h100);
    tick();
    bus.instr_done = 1'b0;
    bus.csr_we     = 1'b0;
    check("mtvec_written", bus.mtvec, 32'h404);

    // Masked pulse, then enable via CSRRW: TAKE right after that retire
    bus.intr = 1'b0;
    idle(4);
    bus.intr = 1'b1;
    idle(2);
    bus.intr = 1'b0;
    idle(4);
    check("pulse_masked", {31'h0, bus.int_taken}, 32'h0);
    retire(1'b1, 1'b0, 12'h300, 32'h8, 32'h100);
    check("enable_take", {31'h0, bus.int_taken}, 32'h1);
    check("enable_mie", {31'h0, bus.mie_out}, 32'h1);
    tick();
    check("enable_take_end", {31'h0, bus.int_taken}, 32'h0);
    check("enable_mepc", bus.mepc, 32'h100);
    check("enable_mie_clr", {31'h0, bus.mie_out}, 32'h0);
    check_rd("enable_mstatus", 12'h300, 32'h80);

    // MRET with pending: MIE restored and TAKE follows immediately
    bus.intr = 1'b1;
    idle(4);
    check("mret_pre", {31'h0, bus.int_taken}, 32'h0);
    retire(1'b0, 1'b1, 12'h0, 32'h0, 32'h200);
    check("mret_take", {31'h0, bus.int_taken}, 32'h1);
    check_rd("mret_mstatus", 12'h300, 32'h88);
    tick();
    check("mret_take_end", {31'h0, bus.int_taken}, 32'h0);
    check("mret_mepc", bus.mepc, 32'h200);
    check_rd("mret_entry_mstatus", 12'h300, 32'h80);

    // intr held high across MRET: no second entry
    retire(1'b0, 1'b1, 12'h0, 32'h0, 32'h204);
    check("level_mie", {31'h0, bus.mie_out}, 32'h1);
    check("level_no_take0", {31'h0, bus.int_taken}, 32'h0);
    retire(1'b0, 1'b0, 12'h0, 32'h0, 32'h208);
    check("level_no_take1", {31'h0, bus.int_taken}, 32'h0);
    tick();
    check("level_no_take2", {31'h0, bus.int_taken}, 32'h0);

    // New edge with MIE=1: waits for retire, then basic entry at 0x48
    bus.intr = 1'b0;
    idle(4);
    bus.intr = 1'b1;
    idle(4);
    check("no_mid_instr", {31'h0, bus.int_taken}, 32'h0);
    retire(1'b0, 1'b0, 12'h0, 32'h0, 32'h48);
    check("basic_take", {31'h0, bus.int_taken}, 32'h1);
    tick();
    check("basic_take_end", {31'h0, bus.int_taken}, 32'h0);
    check("basic_mepc", bus.mepc, 32'h48);
    check("basic_mie", {31'h0, bus.mie_out}, 32'h0);
    check_rd("basic_mstatus", 12'h300, 32'h80);
    tick();
    check("basic_one_cycle", {31'h0, bus.int_taken}, 32'h0);

    // CSR write and MRET together: MRET wins for mstatus
    retire(1'b1, 1'b1, 12'h300, 32'h0, 32'h50);
    check_rd("mret_wins", 12'h300, 32'h88);
    check("mret_wins_no_take", {31'h0, bus.int_taken}, 32'h0);

    // Reset in the middle of TAKE: back to idle, pending lost
    bus.intr = 1'b0;
    idle(4);
    bus.intr = 1'b1;
    idle(4);
    retire(1'b0, 1'b0, 12'h0, 32'h0, 32'h60);
    check("rst_mid_take_pre", {31'h0, bus.int_taken}, 32'h1);
    #2;
    RST = 1'b1;
    #1;
    check("rst_mid_take", {31'h0, bus.int_taken}, 32'h0);
    check("rst_mid_mie", {31'h0, bus.mie_out}, 32'h0);
    check("rst_mid_mepc", bus.mepc, 32'h0);
    check("rst_mid_mtvec", bus.mtvec, 32'h0);
    bus.intr = 1'b0;
    tick();
    RST = 1'b0;
    idle(4);
    retire(1'b1, 1'b0, 12'h300, 32'h8, 32'h70);
    check("pending_lost_mie", {31'h0, bus.mie_out}, 32'h1);
    check("pending_lost", {31'h0, bus.int_taken}, 32'h0);
    tick();
    check("pending_lost2", {31'h0, bus.int_taken}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
